// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control path:
// opcodes, FSM states, ALU control classes and datapath mux selects.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JAL      = 4'd12,
    ST_JR       = 4'd13,
    ST_HALT     = 4'd14
  } ctrl_state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_BEQ   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_ADDI  = 3'd3;
  localparam logic [2:0] ALUOP_SLTI  = 3'd4;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port handshake between the control FSM and the memory.
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_read_o;
    logic mem_write_o;
    logic i_or_d_o;
    logic mem_ready_i;

    modport master (output mem_req_o, mem_read_o, mem_write_o, i_or_d_o,
                    input  mem_ready_i);
    modport slave  (input  mem_req_o, mem_read_o, mem_write_o, i_or_d_o,
                    output mem_ready_i);
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Counts stalled memory cycles and raises a sticky error when the
// memory has not answered within TIMEOUT cycles.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    input  logic ready_i,
    output logic timeout_o,
    output logic mem_err_o
);
    logic [CNT_W-1:0] cnt;

    assign timeout_o = (TIMEOUT != 0) && wait_i && !ready_i &&
                       (cnt == CNT_W'(TIMEOUT));

    // Any exit from a stall (ready, timeout, or a non-memory state) clears the count.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt       <= '0;
            mem_err_o <= 1'b0;
        end else begin
            if (wait_i && !ready_i && !timeout_o) cnt <= cnt + 1'b1;
            else                                  cnt <= '0;
            if (timeout_o) mem_err_o <= 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences each instruction
// through fetch/decode/execute/memory/writeback with a stallable memory port.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multicycle_ctrl_if.master   mem,
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          funct_i,
    input  logic                zero_i,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic [1:0]          pc_src_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                reg_write_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                illegal_o,
    output logic                mem_err_o,
    output logic [3:0]          state_o
);
    ctrl_state_t state;
    logic        ready, in_wait, timeout;
    logic        decode_ok;
    logic        unused_zero;

    // The branch decision itself is made in the datapath via pc_write_cond.
    assign unused_zero = zero_i;
    assign ready       = mem.mem_ready_i;
    assign in_wait     = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign state_o     = state;
    assign decode_ok   = (opcode_i == OP_RTYPE) || (opcode_i == OP_ADDI) ||
                         (opcode_i == OP_SLTI)  || (opcode_i == OP_LW)   ||
                         (opcode_i == OP_SW)    || (opcode_i == OP_BEQ)  ||
                         (opcode_i == OP_J)     || (opcode_i == OP_JAL);

    ctrl_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wait_i    (in_wait),
        .ready_i   (ready),
        .timeout_o (timeout),
        .mem_err_o (mem_err_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:    if (timeout) state <= ST_HALT;
                             else if (ready) state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode_i)
                        OP_RTYPE: state <= (funct_i == FUNCT_JR) ? ST_JR : ST_EXEC_R;
                        OP_ADDI, OP_SLTI: state <= ST_EXEC_I;
                        OP_LW, OP_SW:     state <= ST_MEM_ADDR;
                        OP_BEQ:           state <= ST_BRANCH;
                        OP_J:             state <= ST_JUMP;
                        OP_JAL:           state <= ST_JAL;
                        default:          state <= ST_FETCH;
                    endcase
                end
                ST_EXEC_R:   state <= ST_WB_R;
                ST_EXEC_I:   state <= ST_WB_I;
                ST_MEM_ADDR: state <= (opcode_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   if (timeout) state <= ST_HALT;
                             else if (ready) state <= ST_MEM_WB;
                ST_MEM_WR:   if (timeout) state <= ST_HALT;
                             else if (ready) state <= ST_FETCH;
                ST_HALT:     state <= ST_HALT;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        mem.mem_req_o   = 1'b0;
        mem.mem_read_o  = 1'b0;
        mem.mem_write_o = 1'b0;
        mem.i_or_d_o    = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = PC_SRC_ALU;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRC_B_RT;
        alu_op_o        = ALU_OP_W'(ALUOP_ADD);
        reg_write_o     = 1'b0;
        reg_dst_o       = DST_RT;
        mem_to_reg_o    = WB_ALUOUT;
        illegal_o       = 1'b0;
        case (state)
            ST_FETCH: begin
                mem.mem_req_o  = !timeout;
                mem.mem_read_o = !timeout;
                alu_src_b_o    = SRC_B_FOUR;
                ir_write_o     = ready;
                pc_write_o     = ready;
            end
            ST_DECODE: begin
                alu_src_b_o = SRC_B_IMM_SH;
                illegal_o   = !decode_ok;
            end
            ST_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_OP_W'(ALUOP_RTYPE);
            end
            ST_WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = DST_RD;
            end
            ST_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = (opcode_i == OP_ADDI) ? ALU_OP_W'(ALUOP_ADDI)
                                                    : ALU_OP_W'(ALUOP_SLTI);
            end
            ST_WB_I:     reg_write_o = 1'b1;
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                mem.mem_req_o  = !timeout;
                mem.mem_read_o = !timeout;
                mem.i_or_d_o   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = WB_MDR;
            end
            ST_MEM_WR: begin
                mem.mem_req_o   = !timeout;
                mem.mem_write_o = !timeout;
                mem.i_or_d_o    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_OP_W'(ALUOP_BEQ);
                pc_write_cond_o = 1'b1;
                pc_src_o        = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_SRC_JUMP;
            end
            ST_JAL: begin
                pc_write_o   = 1'b1;
                pc_src_o     = PC_SRC_JUMP;
                reg_write_o  = 1'b1;
                reg_dst_o    = DST_RA;
                mem_to_reg_o = WB_PC;
            end
            ST_JR: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_SRC_RS;
            end
            default: ;
        endcase
    end
endmodule
